// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
//  Module   : mips_defs (package)
//  Brief    : Shared execute-stage definitions: ALU op codes, ALU result
//             types and the multiply/divide unit state encoding.
//  Revision : 1.0 - initial release with MULT/MULTU/DIV/DIVU support
// ============================================================================
package mips_defs;

    // ALU operation codes for the multiply/divide group
    localparam logic [7:0] EXE_MULT  = 8'h14;
    localparam logic [7:0] EXE_MULTU = 8'h15;
    localparam logic [7:0] EXE_DIV   = 8'h16;
    localparam logic [7:0] EXE_DIVU  = 8'h17;

    // ALU result type codes used by the execute-stage result mux
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;
    localparam logic [2:0] EXE_RES_MUL   = 3'b101;

    // Multiply/divide unit sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

endpackage : mips_defs
`default_nettype wire

// File: rtl/div_radix2.sv
`default_nettype none
// ============================================================================
//  Module   : div_radix2
//  Brief    : Iterative unsigned radix-2 restoring divider. One quotient bit
//             per cycle; done_o flags the final iteration and the quotient/
//             remainder outputs carry that iteration's result combinationally
//             so the caller can register it on the same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module div_radix2 #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int                 c_cnt_w = $clog2(XLEN + 1);
    localparam logic [c_cnt_w-1:0] c_iters = c_cnt_w'(XLEN);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(1);

    logic               r_busy;
    logic [c_cnt_w-1:0] r_cnt;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_dsr;

    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_diff;
    logic               w_fits;
    logic [XLEN-1:0]    w_rem_next;
    logic [XLEN-1:0]    w_quo_next;

    // Trial subtraction: shift the next dividend bit into the partial
    // remainder and keep the difference only if it did not go negative.
    assign w_shift    = {r_rem, r_quo[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, r_dsr};
    assign w_fits     = ~w_diff[XLEN];
    assign w_rem_next = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_next = {r_quo[XLEN-2:0], w_fits};

    assign done_o      = r_busy && (r_cnt == c_last);
    assign quotient_o  = w_quo_next;
    assign remainder_o = w_rem_next;

    // Load operands on start, then retire one quotient bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dsr  <= '0;
        end else if (abort_i) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start_i) begin
            r_busy <= 1'b1;
            r_cnt  <= c_iters;
            r_rem  <= '0;
            r_quo  <= dividend_i;
            r_dsr  <= divisor_i;
        end else if (r_busy) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - c_last;
            if (r_cnt == c_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule : div_radix2
`default_nettype wire

// File: rtl/exe_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : exe_muldiv_unit
//  Brief    : Multi-cycle MULT/MULTU/DIV/DIVU engine for the execute stage.
//             Stalls the pipe while working, then presents {HI, LO} for one
//             cycle with done_o so it travels with the owning instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module exe_muldiv_unit
    import mips_defs::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int ALUOP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ALUOP_W-1:0] exe_aluop_i,
    input  logic [XLEN-1:0]   exe_src1_i,
    input  logic [XLEN-1:0]   exe_src2_i,
    input  logic              start_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [2*XLEN-1:0] hilo_o
);

    localparam int                  c_mcnt_w   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [c_mcnt_w-1:0] c_mul_last = c_mcnt_w'(MUL_LAT - 1);
    localparam logic [c_mcnt_w-1:0] c_mcnt_one = c_mcnt_w'(1);

    muldiv_state_t       r_state;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic                r_signed;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [c_mcnt_w-1:0] r_mcnt;
    logic [2*XLEN-1:0]   r_hilo;

    logic                w_is_mult;
    logic                w_is_multu;
    logic                w_is_div;
    logic                w_is_divu;
    logic                w_is_mul_op;
    logic                w_is_div_op;
    logic                w_is_muldiv;
    logic                w_accept;
    logic                w_div_zero;
    logic                w_div_start;
    logic                w_div_abort;
    logic                w_s1_neg;
    logic                w_s2_neg;
    logic [XLEN-1:0]     w_abs1;
    logic [XLEN-1:0]     w_abs2;
    logic                w_dv_done;
    logic [XLEN-1:0]     w_dv_quo;
    logic [XLEN-1:0]     w_dv_rem;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [2*XLEN-1:0]   w_mul_a;
    logic [2*XLEN-1:0]   w_mul_b;
    logic [2*XLEN-1:0]   w_prod;

    // Operation decode
    assign w_is_mult   = (exe_aluop_i == ALUOP_W'(EXE_MULT));
    assign w_is_multu  = (exe_aluop_i == ALUOP_W'(EXE_MULTU));
    assign w_is_div    = (exe_aluop_i == ALUOP_W'(EXE_DIV));
    assign w_is_divu   = (exe_aluop_i == ALUOP_W'(EXE_DIVU));
    assign w_is_mul_op = w_is_mult | w_is_multu;
    assign w_is_div_op = w_is_div | w_is_divu;
    assign w_is_muldiv = w_is_mul_op | w_is_div_op;

    // Acceptance happens only from IDLE; a flush in the same cycle wins
    assign w_accept    = (r_state == IDLE) && start_i && w_is_muldiv && !flush_i;
    assign w_div_zero  = (exe_src2_i == '0);
    assign w_div_start = w_accept && w_is_div_op && !w_div_zero;
    assign w_div_abort = flush_i && (r_state == DIV);

    // Signed divide works on magnitudes; the most negative value maps onto
    // itself, which is already its correct unsigned magnitude.
    assign w_s1_neg = w_is_div && exe_src1_i[XLEN-1];
    assign w_s2_neg = w_is_div && exe_src2_i[XLEN-1];
    assign w_abs1   = w_s1_neg ? (-exe_src1_i) : exe_src1_i;
    assign w_abs2   = w_s2_neg ? (-exe_src2_i) : exe_src2_i;

    div_radix2 #(
        .XLEN (XLEN)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (w_div_start),
        .abort_i     (w_div_abort),
        .dividend_i  (w_abs1),
        .divisor_i   (w_abs2),
        .done_o      (w_dv_done),
        .quotient_o  (w_dv_quo),
        .remainder_o (w_dv_rem)
    );

    // Sign post-processing of the unsigned divider result
    assign w_quo_fix = r_neg_q ? (-w_dv_quo) : w_dv_quo;
    assign w_rem_fix = r_neg_r ? (-w_dv_rem) : w_dv_rem;

    // Full-width product: extend both operands to 2*XLEN, the low 2*XLEN
    // bits of the product are then exact for both signed and unsigned.
    assign w_mul_a = r_signed ? {{XLEN{r_a[XLEN-1]}}, r_a} : {{XLEN{1'b0}}, r_a};
    assign w_mul_b = r_signed ? {{XLEN{r_b[XLEN-1]}}, r_b} : {{XLEN{1'b0}}, r_b};
    assign w_prod  = w_mul_a * w_mul_b;

    // Sequencer: operand capture, multiply latency count, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_mcnt   <= '0;
            r_hilo   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul_op) begin
                            r_a      <= exe_src1_i;
                            r_b      <= exe_src2_i;
                            r_signed <= w_is_mult;
                            r_mcnt   <= '0;
                            r_state  <= MUL;
                        end else if (w_div_zero) begin
                            r_hilo  <= {exe_src1_i, {XLEN{1'b1}}};
                            r_state <= DONE;
                        end else begin
                            r_neg_q <= w_s1_neg ^ w_s2_neg;
                            r_neg_r <= w_s1_neg;
                            r_state <= DIV;
                        end
                    end
                end
                MUL: begin
                    if (flush_i) begin
                        r_state <= IDLE;
                    end else if (r_mcnt == c_mul_last) begin
                        r_hilo  <= w_prod;
                        r_state <= DONE;
                    end else begin
                        r_mcnt <= r_mcnt + c_mcnt_one;
                    end
                end
                DIV: begin
                    if (flush_i) begin
                        r_state <= IDLE;
                    end else if (w_dv_done) begin
                        r_hilo  <= {w_rem_fix, w_quo_fix};
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the pipe freezes already in the accept cycle
    assign stall_o = ((r_state == IDLE) && start_i && w_is_muldiv) ||
                     (r_state == MUL) || (r_state == DIV);
    assign busy_o  = (r_state != IDLE);
    // A flush landing in the DONE cycle kills the result pulse
    assign done_o  = (r_state == DONE) && !flush_i;
    assign hilo_o  = r_hilo;

endmodule : exe_muldiv_unit
`default_nettype wire

// File: tb/tb_exe_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exe_muldiv_unit
//  Brief    : Self-checking bench for exe_muldiv_unit: directed corner cases,
//             flush/reset aborts, back-to-back ops and random operations
//             compared against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exe_muldiv_unit;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int ALUOP_W = 8;

    localparam logic [7:0] OP_MULT  = 8'h14;
    localparam logic [7:0] OP_MULTU = 8'h15;
    localparam logic [7:0] OP_DIV   = 8'h16;
    localparam logic [7:0] OP_DIVU  = 8'h17;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        aluop;
    logic [31:0]       src1;
    logic [31:0]       src2;
    logic              start;
    logic              flush;
    logic              stall_o;
    logic              busy_o;
    logic              done_o;
    logic [63:0]       hilo_o;

    int                compared   = 0;
    int                mismatched = 0;
    logic [63:0]       last_hilo;

    exe_muldiv_unit #(
        .XLEN    (XLEN),
        .MUL_LAT (MUL_LAT),
        .ALUOP_W (ALUOP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exe_aluop_i (aluop),
        .exe_src1_i  (src1),
        .exe_src2_i  (src2),
        .start_i     (start),
        .flush_i     (flush),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .hilo_o      (hilo_o)
    );

    always #5 clk = ~clk;

    // Reference result straight from the arithmetic definition of each op
    function automatic logic [63:0] ref_hilo(input logic [7:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0]        ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            OP_MULT:  return sa * sb;
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [7:0] op, input logic [31:0] b);
        if (op == OP_MULT || op == OP_MULTU) return MUL_LAT + 1;
        if (b == 32'd0) return 1;
        return XLEN + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation at cycle 0 and follow it until done_o (bounded)
    task automatic run_op(input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        int   cyc;
        bit   seen;
        bit   stall_ok;
        logic [63:0] exp;
        exp = ref_hilo(op, a, b);
        @(negedge clk);
        aluop = op; src1 = a; src2 = b; start = 1'b1;
        #1 chk({tag, " stall@0"}, stall_o, 1'b1);
        cyc = 0; seen = 0; stall_ok = 1;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; src1 = $urandom; src2 = $urandom; aluop = 8'($urandom);
            #1;
            if (done_o) seen = 1;
            else if (stall_o !== 1'b1) stall_ok = 0;
        end
        chk({tag, " stall busy"}, stall_ok, 1'b1);
        chk({tag, " latency"}, cyc, ref_lat(op, b));
        chk({tag, " hilo"}, hilo_o, exp);
        chk({tag, " stall@done"}, stall_o, 1'b0);
        chk({tag, " busy@done"}, busy_o, 1'b1);
        last_hilo = exp;
    endtask

    // The cycle after done: back in IDLE with the result held
    task automatic idle_chk(input string tag);
        @(negedge clk);
        #1;
        chk({tag, " idle done"}, done_o, 1'b0);
        chk({tag, " idle busy"}, busy_o, 1'b0);
        chk({tag, " idle hold"}, hilo_o, last_hilo);
    endtask

    // Watch a window of cycles and require that no done pulse appears
    task automatic no_done(input string tag, input int n);
        int pulses;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1 if (done_o) pulses++;
        end
        chk({tag, " no done"}, pulses, 0);
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] a, b;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        aluop = 8'h00; src1 = '0; src2 = '0;
        last_hilo = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset hilo", hilo_o, 64'd0);
        chk("reset done", done_o, 1'b0);
        chk("reset busy", busy_o, 1'b0);
        chk("reset stall", stall_o, 1'b0);
        rst_n = 1'b1;

        // Directed corner cases
        run_op(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, "mult neg");   idle_chk("mult neg");
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");  idle_chk("multu max");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div -7/2");   idle_chk("div -7/2");
        run_op(OP_DIVU,  32'd100,       32'd7,         "divu 100/7"); idle_chk("divu 100/7");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div min/-1"); idle_chk("div min/-1");
        run_op(OP_DIVU,  32'd5,         32'd0,         "divu 5/0");   idle_chk("divu 5/0");
        run_op(OP_DIV,   32'hFFFF_FFF0, 32'd0,         "div neg/0");  idle_chk("div neg/0");

        // Non-muldiv op with start is ignored
        @(negedge clk);
        aluop = 8'h20; src1 = 32'd9; src2 = 32'd3; start = 1'b1;
        #1 chk("other op stall", stall_o, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #1 chk("other op busy", busy_o, 1'b0);

        // Flush beats start in IDLE
        @(negedge clk);
        aluop = OP_DIV; src1 = 32'd50; src2 = 32'd5; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 chk("flush prio busy", busy_o, 1'b0);

        // Flush a divide at cycle 10
        @(negedge clk);
        aluop = OP_DIV; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1 chk("flush pre done", done_o, 1'b0);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush busy", busy_o, 1'b0);
        chk("flush stall", stall_o, 1'b0);
        chk("flush done", done_o, 1'b0);
        no_done("flush", 40);

        // Back-to-back: second op issued right after the first done cycle
        run_op(OP_MULT, 32'h0001_2345, 32'hFFFF_0002, "b2b mult");
        run_op(OP_DIV,  32'h7654_3210, 32'hFFFF_FF03, "b2b div");
        idle_chk("b2b div");

        // Random operations against the reference model
        for (int n = 0; n < 24; n++) begin
            op = 8'(OP_MULT + 8'($urandom_range(0, 3)));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = 32'($urandom);
            endcase
            run_op(op, a, b, $sformatf("rand%0d op%h", n, op));
            idle_chk($sformatf("rand%0d", n));
        end

        // Asynchronous reset in the middle of a divide
        run_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, "pre reset");
        @(negedge clk);
        aluop = OP_DIV; src1 = 32'd12345; src2 = 32'd17; start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid reset hilo", hilo_o, 64'd0);
        chk("mid reset done", done_o, 1'b0);
        chk("mid reset busy", busy_o, 1'b0);
        chk("mid reset stall", stall_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        no_done("mid reset", 40);
        chk("post reset hilo", hilo_o, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_exe_muldiv_unit
`default_nettype wire
